// File: rtl/btn_event_gen.sv
// Multi-channel push-button conditioner: synchroniser, debounce, registered edge
// pulses, and long-press detection with optional auto-repeat on evt.
module btn_event_gen #(
    parameter int CH           = 5,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int EDGE_MODE    = 0,
    parameter int HOLD_CYC     = 100_000_000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_CYC   = 20_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] evt,
    output logic [CH-1:0] held
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int RW = $clog2(REPEAT_CYC + 1);

    // Terminal counts: the counter value seen in the cycle before the event fires.
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_CYC - 1);
    localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYC - 1);
    localparam logic          REP_ON = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HOLD  = 2'd2
    } lp_state_t;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            logic [DW-1:0]          dcnt_reg, dcnt_next;
            logic                   level_reg, level_next, level_d_reg;
            logic                   rise_reg, rise_next;
            logic                   fall_reg, fall_next;
            logic                   evt_reg, evt_next, edge_evt;
            logic                   held_reg, held_next;
            logic                   rep_next;
            lp_state_t              state_reg, state_next;
            logic [HW-1:0]          hcnt_reg, hcnt_next;
            logic [RW-1:0]          rcnt_reg, rcnt_next;

            assign s = sync_reg[SYNC_STAGES-1];

            // A glitch that returns to the accepted level, even on the would-be
            // acceptance cycle, simply restarts the count.
            always_comb begin
                dcnt_next  = '0;
                level_next = level_reg;
                if (s != level_reg) begin
                    if (dcnt_reg >= DMAX) begin
                        level_next = s;
                    end else begin
                        dcnt_next = dcnt_reg + 1'b1;
                    end
                end
            end

            assign rise_next = level_reg & ~level_d_reg;
            assign fall_next = ~level_reg & level_d_reg;

            // Leaving PRESS/HOLD is keyed off the debounced level so that the
            // state, held and the repeat stream all drop in the fall cycle.
            always_comb begin
                state_next = state_reg;
                hcnt_next  = hcnt_reg;
                rcnt_next  = rcnt_reg;
                held_next  = held_reg;
                rep_next   = 1'b0;
                unique case (state_reg)
                    ST_IDLE: begin
                        hcnt_next = '0;
                        rcnt_next = '0;
                        held_next = 1'b0;
                        if (rise_reg && level_reg) begin
                            state_next = ST_PRESS;
                            hcnt_next  = HW'(1);
                        end
                    end
                    ST_PRESS: begin
                        if (!level_reg) begin
                            state_next = ST_IDLE;
                            hcnt_next  = '0;
                            rcnt_next  = '0;
                            held_next  = 1'b0;
                        end else if (hcnt_reg >= HMAX) begin
                            state_next = ST_HOLD;
                            held_next  = 1'b1;
                            rcnt_next  = '0;
                            rep_next   = REP_ON;
                        end else begin
                            hcnt_next = hcnt_reg + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!level_reg) begin
                            state_next = ST_IDLE;
                            hcnt_next  = '0;
                            rcnt_next  = '0;
                            held_next  = 1'b0;
                        end else if (rcnt_reg >= RMAX) begin
                            rcnt_next = '0;
                            rep_next  = REP_ON;
                        end else begin
                            rcnt_next = rcnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        hcnt_next  = '0;
                        rcnt_next  = '0;
                        held_next  = 1'b0;
                    end
                endcase
            end

            always_comb begin
                if (EDGE_MODE == 0) begin
                    edge_evt = rise_next;
                end else if (EDGE_MODE == 1) begin
                    edge_evt = fall_next;
                end else begin
                    edge_evt = rise_next | fall_next;
                end
                evt_next = edge_evt | rep_next;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg    <= '0;
                    dcnt_reg    <= '0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    rise_reg    <= 1'b0;
                    fall_reg    <= 1'b0;
                    evt_reg     <= 1'b0;
                    held_reg    <= 1'b0;
                    state_reg   <= ST_IDLE;
                    hcnt_reg    <= '0;
                    rcnt_reg    <= '0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
                    dcnt_reg    <= dcnt_next;
                    level_reg   <= level_next;
                    level_d_reg <= level_reg;
                    rise_reg    <= rise_next;
                    fall_reg    <= fall_next;
                    evt_reg     <= evt_next;
                    held_reg    <= held_next;
                    state_reg   <= state_next;
                    hcnt_reg    <= hcnt_next;
                    rcnt_reg    <= rcnt_next;
                end
            end

            assign level[gi] = level_reg;
            assign rise[gi]  = rise_reg;
            assign fall[gi]  = fall_reg;
            assign evt[gi]   = evt_reg;
            assign held[gi]  = held_reg;
        end
    endgenerate

endmodule
